connect_mode_ctrl: RTL and testbench

Mode sequencer for the CONNECT routing block. Owns the single ENABLE line that selects between the bypass path (CNN engine ↔ XHB) and the compressed path through AIDC. It tracks outstanding AXI read and write transactions on the XHB side. A mode change is applied only at a quiescent point: new address issue is held off, the bus is drained, AIDC is confirmed idle, then ENABLE flips and the datapath settles.

---
 rtl/connect_mode_ctrl_if.sv | 41 ++++
 rtl/connect_mode_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_connect_mode_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/connect_mode_ctrl_if.sv
// Handshake and status bundle between the CONNECT mode sequencer and its environment.
interface connect_mode_ctrl_if #(
   parameter int unsigned CNT_W = 4
);
   logic             REQ_VALID_i;
   logic             REQ_MODE_i;
   logic             REQ_READY_o;
   logic             ARVALID_i;
   logic             ARREADY_i;
   logic             AWVALID_i;
   logic             AWREADY_i;
   logic             RVALID_i;
   logic             RREADY_i;
   logic             RLAST_i;
   logic             BVALID_i;
   logic             BREADY_i;
   logic             AIDC_BUSY_i;
   logic             ERR_CLR_i;
   logic             ENABLE_o;
   logic             HOLD_o;
   logic             DONE_o;
   logic             TIMEOUT_o;
   logic             ERR_o;
   logic [1:0]       STATE_o;
   logic [CNT_W-1:0] RD_CNT_o;
   logic [CNT_W-1:0] WR_CNT_o;

   modport master (
      output REQ_VALID_i, REQ_MODE_i, ARVALID_i, ARREADY_i, AWVALID_i, AWREADY_i,
             RVALID_i, RREADY_i, RLAST_i, BVALID_i, BREADY_i, AIDC_BUSY_i, ERR_CLR_i,
      input  REQ_READY_o, ENABLE_o, HOLD_o, DONE_o, TIMEOUT_o, ERR_o, STATE_o,
             RD_CNT_o, WR_CNT_o
   );

   modport slave (
      input  REQ_VALID_i, REQ_MODE_i, ARVALID_i, ARREADY_i, AWVALID_i, AWREADY_i,
             RVALID_i, RREADY_i, RLAST_i, BVALID_i, BREADY_i, AIDC_BUSY_i, ERR_CLR_i,
      output REQ_READY_o, ENABLE_o, HOLD_o, DONE_o, TIMEOUT_o, ERR_o, STATE_o,
             RD_CNT_o, WR_CNT_o
   );
endinterface

// File: rtl/connect_mode_ctrl.sv
// Mode sequencer owning CONNECT ENABLE: drains XHB traffic and AIDC before flipping modes.
// Optional drain abort enabled by defining CONNECT_DRAIN_TIMEOUT_EN.
module connect_mode_ctrl #(
   parameter int unsigned CNT_W          = 4,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic               CLK_i,
   input logic               RST_i,
   connect_mode_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_enable;
   logic             r_target;
   logic             r_done;
   logic             r_timeout;
   logic             r_err;
   logic [CNT_W-1:0] r_rd_cnt;
   logic [CNT_W-1:0] r_wr_cnt;
   logic [7:0]       r_settle_cnt;

   logic             w_ar;
   logic             w_aw;
   logic             w_r;
   logic             w_b;
   logic [CNT_W-1:0] w_rd_nxt;
   logic [CNT_W-1:0] w_wr_nxt;
   logic             w_rd_err;
   logic             w_wr_err;
   logic             w_quiet;
   logic             w_hold;
   logic             w_ready;
   logic             w_done_nxt;
   logic             w_timeout_nxt;
   logic             w_latch_target;
   logic             w_to_expired;

   assign w_ar = bus.ARVALID_i & bus.ARREADY_i;
   assign w_aw = bus.AWVALID_i & bus.AWREADY_i;
   assign w_r  = bus.RVALID_i & bus.RREADY_i & bus.RLAST_i;
   assign w_b  = bus.BVALID_i & bus.BREADY_i;

   // Saturating counters; an event that would wrap is flagged instead of applied.
   always_comb begin
      w_rd_nxt = r_rd_cnt;
      w_rd_err = 1'b0;
      if (w_ar && !w_r) begin
         if (r_rd_cnt == '1) w_rd_err = 1'b1;
         else                w_rd_nxt = r_rd_cnt + 1'b1;
      end else if (w_r && !w_ar) begin
         if (r_rd_cnt == '0) w_rd_err = 1'b1;
         else                w_rd_nxt = r_rd_cnt - 1'b1;
      end
   end

   always_comb begin
      w_wr_nxt = r_wr_cnt;
      w_wr_err = 1'b0;
      if (w_aw && !w_b) begin
         if (r_wr_cnt == '1) w_wr_err = 1'b1;
         else                w_wr_nxt = r_wr_cnt + 1'b1;
      end else if (w_b && !w_aw) begin
         if (r_wr_cnt == '0) w_wr_err = 1'b1;
         else                w_wr_nxt = r_wr_cnt - 1'b1;
      end
   end

   assign w_quiet = (r_rd_cnt == '0) && (r_wr_cnt == '0) && !bus.AIDC_BUSY_i && !w_ar && !w_aw;

`ifdef CONNECT_DRAIN_TIMEOUT_EN
   localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;

   // Always zero outside DRAIN, so it is clear on every DRAIN entry.
   always_ff @(posedge CLK_i) begin
      if (RST_i || r_state != ST_DRAIN) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + 1'b1;
   end

   assign w_to_expired = (r_to_cnt == TO_LAST);
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   assign w_to_expired = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_hold         = 1'b1;
      w_ready        = 1'b0;
      w_done_nxt     = 1'b0;
      w_timeout_nxt  = 1'b0;
      w_latch_target = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_hold  = 1'b0;
            w_ready = 1'b1;
            if (bus.REQ_VALID_i) begin
               if (bus.REQ_MODE_i == r_enable) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_latch_target = 1'b1;
                  w_state_nxt    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_quiet) begin
               w_state_nxt = ST_SWITCH;
            end else if (w_to_expired) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = ST_RUN;
            end
         end
         ST_SWITCH: w_state_nxt = ST_SETTLE;
         ST_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         r_enable     <= 1'b0;
         r_target     <= 1'b0;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
         r_err        <= 1'b0;
         r_rd_cnt     <= '0;
         r_wr_cnt     <= '0;
         r_settle_cnt <= '0;
      end else begin
         r_done    <= w_done_nxt;
         r_timeout <= w_timeout_nxt;
         r_rd_cnt  <= w_rd_nxt;
         r_wr_cnt  <= w_wr_nxt;
         if (w_latch_target)        r_target <= bus.REQ_MODE_i;
         if (r_state == ST_SWITCH)  r_enable <= r_target;
         if (r_state == ST_SETTLE)  r_settle_cnt <= r_settle_cnt + 1'b1;
         else                       r_settle_cnt <= '0;
         if (w_rd_err || w_wr_err)  r_err <= 1'b1;
         else if (bus.ERR_CLR_i)    r_err <= 1'b0;
      end
   end

   assign bus.REQ_READY_o = w_ready;
   assign bus.HOLD_o      = w_hold;
   assign bus.ENABLE_o    = r_enable;
   assign bus.DONE_o      = r_done;
   assign bus.TIMEOUT_o   = r_timeout;
   assign bus.ERR_o       = r_err;
   assign bus.STATE_o     = r_state;
   assign bus.RD_CNT_o    = r_rd_cnt;
   assign bus.WR_CNT_o    = r_wr_cnt;

endmodule

// File: tb/tb_connect_mode_ctrl.sv
// Bench for connect_mode_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_connect_mode_ctrl;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned TO_CYC = 16;
   localparam int          MAXC   = (1 << CNT_W) - 1;

   logic CLK = 1'b0;
   logic RST;
   int   n_cmp = 0;
   int   n_bad = 0;

   connect_mode_ctrl_if #(.CNT_W(CNT_W)) bus ();

   connect_mode_ctrl #(
      .CNT_W(CNT_W),
      .SETTLE_CYCLES(SETTLE),
      .TIMEOUT_CYCLES(TO_CYC)
   ) u_dut (
      .CLK_i(CLK),
      .RST_i(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   // Reference model: phase numbers follow the published STATE_o values.
   int m_phase, m_rd, m_wr, m_settle_left, m_drain_cycles;
   bit m_en, m_target, m_done, m_to, m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit ar, aw, r, b, set_err, quiet;
      ar = bus.ARVALID_i && bus.ARREADY_i;
      aw = bus.AWVALID_i && bus.AWREADY_i;
      r  = bus.RVALID_i && bus.RREADY_i && bus.RLAST_i;
      b  = bus.BVALID_i && bus.BREADY_i;
      if (RST) begin
         m_phase = 0; m_rd = 0; m_wr = 0; m_en = 0; m_target = 0;
         m_done = 0; m_to = 0; m_err = 0; m_settle_left = 0; m_drain_cycles = 0;
         return;
      end
      quiet = (m_rd == 0) && (m_wr == 0) && !bus.AIDC_BUSY_i && !ar && !aw;
      set_err = 0;
      if (ar && !r) begin if (m_rd == MAXC) set_err = 1; else m_rd++; end
      if (r && !ar) begin if (m_rd == 0) set_err = 1; else m_rd--; end
      if (aw && !b) begin if (m_wr == MAXC) set_err = 1; else m_wr++; end
      if (b && !aw) begin if (m_wr == 0) set_err = 1; else m_wr--; end
      if (set_err) m_err = 1;
      else if (bus.ERR_CLR_i) m_err = 0;
      m_done = 0;
      m_to   = 0;
      case (m_phase)
         0: if (bus.REQ_VALID_i) begin
               if (bus.REQ_MODE_i == m_en) m_done = 1;
               else begin m_target = bus.REQ_MODE_i; m_phase = 1; m_drain_cycles = 0; end
            end
         1: if (quiet) m_phase = 2;
            else begin
               m_drain_cycles++;
`ifdef CONNECT_DRAIN_TIMEOUT_EN
               if (m_drain_cycles == TO_CYC) begin m_phase = 0; m_to = 1; end
`endif
            end
         2: begin m_en = m_target; m_phase = 3; m_settle_left = SETTLE; end
         default: begin
            m_settle_left--;
            if (m_settle_left == 0) begin m_phase = 0; m_done = 1; end
         end
      endcase
   endtask

   task automatic tick();
      model_step();
      @(negedge CLK);
      chk("state", bus.STATE_o, m_phase);
      chk("enable", bus.ENABLE_o, m_en);
      chk("hold", bus.HOLD_o, m_phase != 0);
      chk("ready", bus.REQ_READY_o, m_phase == 0);
      chk("done", bus.DONE_o, m_done);
      chk("timeout", bus.TIMEOUT_o, m_to);
      chk("err", bus.ERR_o, m_err);
      chk("rd_cnt", bus.RD_CNT_o, m_rd);
      chk("wr_cnt", bus.WR_CNT_o, m_wr);
   endtask

   task automatic idle();
      RST = 0;
      bus.REQ_VALID_i = 0; bus.REQ_MODE_i = 0;
      bus.ARVALID_i = 0; bus.ARREADY_i = 0; bus.AWVALID_i = 0; bus.AWREADY_i = 0;
      bus.RVALID_i = 0; bus.RREADY_i = 0; bus.RLAST_i = 0;
      bus.BVALID_i = 0; bus.BREADY_i = 0;
      bus.AIDC_BUSY_i = 0; bus.ERR_CLR_i = 0;
   endtask

   task automatic ar_hs(input bit v); bus.ARVALID_i = v; bus.ARREADY_i = v; endtask
   task automatic aw_hs(input bit v); bus.AWVALID_i = v; bus.AWREADY_i = v; endtask
   task automatic r_hs(input bit v);  bus.RVALID_i = v; bus.RREADY_i = v; bus.RLAST_i = v; endtask
   task automatic b_hs(input bit v);  bus.BVALID_i = v; bus.BREADY_i = v; endtask

   initial begin
      idle();
      RST = 1;
      @(negedge CLK);
      tick();
      RST = 0;
      chk("rst_state", bus.STATE_o, 0);
      chk("rst_ready", bus.REQ_READY_o, 1);
      chk("rst_enable", bus.ENABLE_o, 0);

      // Idle-bus switch to compressed: latency checked against fixed cycle numbers.
      bus.REQ_VALID_i = 1; bus.REQ_MODE_i = 1;
      tick();
      bus.REQ_VALID_i = 0;
      for (int k = 1; k <= 7; k++) begin
         chk("lat_hold", bus.HOLD_o, (k <= 6));
         chk("lat_enable", bus.ENABLE_o, (k >= 3));
         chk("lat_done", bus.DONE_o, (k == 7));
         if (k < 7) tick();
      end

      // Request for the current mode is a no-op acknowledged one cycle later.
      bus.REQ_VALID_i = 1; bus.REQ_MODE_i = 1;
      tick();
      bus.REQ_VALID_i = 0;
      chk("same_done", bus.DONE_o, 1);
      chk("same_hold", bus.HOLD_o, 0);
      tick();

      // Outstanding traffic keeps the sequencer in DRAIN.
      for (int i = 0; i < 3; i++) begin ar_hs(1); aw_hs(i < 2); tick(); end
      ar_hs(0); aw_hs(0);
      bus.REQ_VALID_i = 1; bus.REQ_MODE_i = 0;
      tick();
      bus.REQ_VALID_i = 0;
      for (int i = 0; i < 3; i++) begin r_hs(1); b_hs(i < 2); tick(); chk("drain_hold", bus.STATE_o, 1); end
      r_hs(0); b_hs(0);
      bus.AIDC_BUSY_i = 1;
      for (int i = 0; i < 3; i++) begin tick(); chk("busy_drain", bus.STATE_o, 1); end
      bus.AIDC_BUSY_i = 0;
      tick();
      chk("busy_switch", bus.STATE_o, 2);
      for (int i = 0; i < 6; i++) tick();
      chk("mode0_enable", bus.ENABLE_o, 0);

      // Underflow flags error; clear then takes effect.
      r_hs(1); tick(); r_hs(0);
      chk("uflow_rd", bus.RD_CNT_o, 0);
      chk("uflow_err", bus.ERR_o, 1);
      bus.ERR_CLR_i = 1; tick(); bus.ERR_CLR_i = 0;
      chk("clr_err", bus.ERR_o, 0);

      // Simultaneous issue and completion at count 2.
      ar_hs(1); tick(); tick();
      r_hs(1); tick();
      chk("ar_r_same", bus.RD_CNT_o, 2);
      ar_hs(0); tick(); tick(); r_hs(0);
      chk("ar_r_drain", bus.RD_CNT_o, 0);

      // Saturation at the maximum count.
      aw_hs(1);
      for (int i = 0; i < MAXC + 1; i++) tick();
      aw_hs(0);
      chk("sat_wr", bus.WR_CNT_o, MAXC);
      chk("sat_err", bus.ERR_o, 1);
      b_hs(1);
      for (int i = 0; i < MAXC; i++) tick();
      b_hs(0); bus.ERR_CLR_i = 1; tick(); bus.ERR_CLR_i = 0;

      // Reset while settling forces bypass.
      bus.REQ_VALID_i = 1; bus.REQ_MODE_i = 1;
      tick();
      bus.REQ_VALID_i = 0;
      tick(); tick(); tick();
      chk("pre_rst_settle", bus.STATE_o, 3);
      RST = 1; tick(); RST = 0;
      chk("rst_settle_state", bus.STATE_o, 0);
      chk("rst_settle_en", bus.ENABLE_o, 0);

`ifdef CONNECT_DRAIN_TIMEOUT_EN
      ar_hs(1); tick(); ar_hs(0);
      bus.REQ_VALID_i = 1; bus.REQ_MODE_i = 1;
      tick();
      bus.REQ_VALID_i = 0;
      for (int i = 0; i < TO_CYC; i++) tick();
      chk("to_pulse", bus.TIMEOUT_o, 1);
      chk("to_enable", bus.ENABLE_o, 0);
      r_hs(1); tick(); r_hs(0);
`endif

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         RST = ($urandom_range(0, 799) == 0);
         bus.ARVALID_i   = bus.HOLD_o ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
         bus.ARREADY_i   = $urandom_range(0, 1);
         bus.AWVALID_i   = bus.HOLD_o ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
         bus.AWREADY_i   = $urandom_range(0, 1);
         bus.RVALID_i    = $urandom_range(0, 1);
         bus.RREADY_i    = $urandom_range(0, 1);
         bus.RLAST_i     = $urandom_range(0, 1);
         bus.BVALID_i    = $urandom_range(0, 1);
         bus.BREADY_i    = ($urandom_range(0, 3) != 0);
         bus.AIDC_BUSY_i = ($urandom_range(0, 3) == 0);
         bus.ERR_CLR_i   = ($urandom_range(0, 15) == 0);
         bus.REQ_VALID_i = ($urandom_range(0, 7) == 0);
         bus.REQ_MODE_i  = $urandom_range(0, 1);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
